// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU codes, FSM state encoding and the decoded control bundle
// used by multicycle_control_unit and its instruction decoder.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LUI, K_JAL, K_JALR, K_LOAD, K_STORE, K_BRANCH
  } kind_t;

  // br_on_zero: the branch is taken when the ALU zero flag equals this bit
  typedef struct packed {
    kind_t      kind;
    logic [3:0] alu;
    logic       alusrc;
    logic       br_on_zero;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{kind: K_ALU, alu: ALU_ADD, alusrc: 1'b0, br_on_zero: 1'b0};

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational map from an RV32I instruction word to the control bundle and an
// illegal flag. Define BRANCH_FULL_EN to accept BLT/BGE/BLTU/BGEU.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.alu = alu_from_f3(funct3, funct7 == 7'h20);
        if (funct7 == 7'h20)
          illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        else if (funct7 != 7'h00)
          illegal = 1'b1;
      end
      OP_IMM: begin
        ctrl.alusrc = 1'b1;
        ctrl.alu    = alu_from_f3(funct3, funct3 == 3'b101 && funct7 == 7'h20);
      end
      OP_LUI: begin
        ctrl.kind   = K_LUI;
        ctrl.alusrc = 1'b1;
      end
      OP_JAL: ctrl.kind = K_JAL;
      OP_JALR: begin
        ctrl.kind   = K_JALR;
        ctrl.alusrc = 1'b1;
        illegal     = funct3 != 3'b000;
      end
      OP_LOAD: begin
        ctrl.kind   = K_LOAD;
        ctrl.alusrc = 1'b1;
        illegal     = funct3 != 3'b010;
      end
      OP_STORE: begin
        ctrl.kind   = K_STORE;
        ctrl.alusrc = 1'b1;
        illegal     = funct3 != 3'b010;
      end
      OP_BRANCH: begin
        ctrl.kind = K_BRANCH;
        ctrl.alu  = ALU_SUB;
        case (funct3)
          3'b000: ctrl.br_on_zero = 1'b1;
          3'b001: ctrl.br_on_zero = 1'b0;
`ifdef BRANCH_FULL_EN
          // SLT/SLTU yields nonzero when "less than", so BLT* take on !zero
          3'b100: begin ctrl.alu = ALU_SLT;  ctrl.br_on_zero = 1'b0; end
          3'b101: begin ctrl.alu = ALU_SLT;  ctrl.br_on_zero = 1'b1; end
          3'b110: begin ctrl.alu = ALU_SLTU; ctrl.br_on_zero = 1'b0; end
          3'b111: begin ctrl.alu = ALU_SLTU; ctrl.br_on_zero = 1'b1; end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory
// handshakes, wait timeouts and sticky traps. BRANCH_FULL_EN enables BLT/BGE*.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALUCTL_W  = 4,
  parameter int TIMEOUT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                memwrite,
  output logic                mem2reg,
  output logic                alusrc,
  output logic                regwrite,
  output logic [ALUCTL_W-1:0] aluctl,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                is_lui,
  output logic                illegal,
  output logic                mem_timeout,
  output logic [2:0]          state
);

  // Last counter value still allowed to wait; one more idle cycle trips the trap
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  state_t               cur;
  ctrl_t                ctrl_q;
  ctrl_t                dec_ctrl;
  logic                 dec_illegal;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 illegal_q;
  logic                 timeout_q;

  instr_decode u_decode (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= ST_RST;
      ctrl_q    <= CTRL_NOP;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (cur)
        ST_RST: begin
          cur      <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            cur <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            cur       <= ST_TRAP;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          ctrl_q <= dec_ctrl;
          if (dec_illegal) begin
            cur       <= ST_TRAP;
            illegal_q <= 1'b1;
          end else begin
            cur <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (ctrl_q.kind)
            K_LOAD, K_STORE: begin
              cur      <= ST_MEM;
              wait_cnt <= '0;
            end
            K_BRANCH: begin
              cur      <= ST_FETCH;
              wait_cnt <= '0;
            end
            default: cur <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (ctrl_q.kind == K_STORE) begin
              cur      <= ST_FETCH;
              wait_cnt <= '0;
            end else begin
              cur <= ST_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            cur       <= ST_TRAP;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WB: begin
          cur      <= ST_FETCH;
          wait_cnt <= '0;
        end
        ST_TRAP: cur <= ST_TRAP;
        default: cur <= ST_TRAP;
      endcase
    end
  end

  // Handshake-qualified strobes (ir_we, pc_we on a store ack, branch pc_src)
  // follow the same-cycle input so the datapath acts on the ack/zero edge.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    memwrite = 1'b0;
    mem2reg  = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    aluctl   = ALUCTL_W'(ALU_ADD);
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_PLUS4;
    is_lui   = 1'b0;
    case (cur)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      ST_EXEC: begin
        aluctl = ALUCTL_W'(ctrl_q.alu);
        alusrc = ctrl_q.alusrc;
        if (ctrl_q.kind == K_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = (zero == ctrl_q.br_on_zero) ? PC_BRANCH : PC_PLUS4;
        end
      end
      ST_MEM: begin
        aluctl   = ALUCTL_W'(ctrl_q.alu);
        alusrc   = ctrl_q.alusrc;
        dmem_req = 1'b1;
        memwrite = ctrl_q.kind == K_STORE;
        pc_we    = (ctrl_q.kind == K_STORE) && dmem_ack;
      end
      ST_WB: begin
        aluctl   = ALUCTL_W'(ctrl_q.alu);
        alusrc   = ctrl_q.alusrc;
        regwrite = 1'b1;
        pc_we    = 1'b1;
        mem2reg  = ctrl_q.kind == K_LOAD;
        is_lui   = ctrl_q.kind == K_LUI;
        case (ctrl_q.kind)
          K_JAL:   pc_src = PC_JAL;
          K_JALR:  pc_src = PC_JALR;
          default: pc_src = PC_PLUS4;
        endcase
      end
      default: ;
    endcase
  end

  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;
  assign state       = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus
// random instructions compared against an instruction-level reference model.
module tb_multicycle_control_unit;

  localparam int TW        = 3;
  localparam int TO_CYCLES = (2 ** TW) - 1;
  localparam int K_ALU = 0, K_LUI = 1, K_JAL = 2, K_JALR = 3, K_LW = 4, K_SW = 5, K_BR = 6;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [31:0] instr    = '0;
  logic        zero     = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, memwrite, mem2reg, alusrc, regwrite;
  logic        ir_we, pc_we, is_lui, illegal, mem_timeout;
  logic [3:0]  aluctl;
  logic [1:0]  pc_src;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  // ALU code per funct3 for the base (non-alternate) operations
  int r_alu [8] = '{2, 7, 5, 4, 6, 8, 1, 0};

  typedef struct packed {
    bit legal;
    int kind;
    int alu;
    bit imm;
    bit brz;
  } exp_t;

  multicycle_control_unit #(.ALUCTL_W(4), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .memwrite(memwrite),
    .mem2reg(mem2reg), .alusrc(alusrc), .regwrite(regwrite), .aluctl(aluctl),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .is_lui(is_lui),
    .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit (got running, need finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [31:0] ins);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e.legal = 1'b1; e.kind = K_ALU; e.alu = 2; e.imm = 1'b0; e.brz = 1'b0;
    case (op)
      7'h33: begin
        e.alu = r_alu[f3];
        if (f7 == 7'h20) begin
          if (f3 == 3'd0) e.alu = 3;
          else if (f3 == 3'd5) e.alu = 9;
          else e.legal = 1'b0;
        end else if (f7 != 7'h00) e.legal = 1'b0;
      end
      7'h13: begin
        e.imm = 1'b1;
        e.alu = r_alu[f3];
        if (f3 == 3'd5 && f7 == 7'h20) e.alu = 9;
      end
      7'h37: begin e.kind = K_LUI; e.imm = 1'b1; end
      7'h6F: e.kind = K_JAL;
      7'h67: begin e.kind = K_JALR; e.imm = 1'b1; e.legal = (f3 == 3'd0); end
      7'h03: begin e.kind = K_LW; e.imm = 1'b1; e.legal = (f3 == 3'd2); end
      7'h23: begin e.kind = K_SW; e.imm = 1'b1; e.legal = (f3 == 3'd2); end
      7'h63: begin
        e.kind = K_BR;
        e.alu  = 3;
        if (f3 == 3'd0) e.brz = 1'b1;
        else if (f3 == 3'd1) e.brz = 1'b0;
`ifdef BRANCH_FULL_EN
        else if (f3 >= 3'd4) begin
          e.alu = (f3 < 3'd6) ? 5 : 4;
          e.brz = f3[0];
        end
`endif
        else e.legal = 1'b0;
      end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0, 1: r[31:25] = 7'h00;
          2: r[31:25] = 7'h20;
          default: ;
        endcase
      end
      2: begin r[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) r[31:25] = 7'h20; end
      3: r[6:0] = 7'h37;
      4: r[6:0] = 7'h6F;
      5: begin r[6:0] = 7'h67; r[14:12] = 3'b000; end
      6: begin r[6:0] = 7'h03; r[14:12] = 3'b010; end
      7: begin r[6:0] = 7'h23; r[14:12] = 3'b010; end
      8: r[6:0] = 7'h63;
      default: ;
    endcase
    return r;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_strobes", 32'({imem_req, dmem_req, memwrite, mem2reg, alusrc, regwrite,
                                    ir_we, pc_we, pc_src, is_lui, illegal, mem_timeout}), 32'd0);
    checkOutput("rst_aluctl", 32'(aluctl), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_hold_state", 32'(state), 32'd0);
  endtask

  // Drives one instruction from FETCH to its return to FETCH (or TRAP)
  task automatic applyStimulus(input logic [31:0] ins, input int fdly, input int mdly,
                               input bit z, output bit trapped);
    exp_t e;
    bit   acked;
    bit   taken;
    e       = ref_model(ins);
    trapped = 1'b0;
    acked   = 1'b0;
    for (int i = 0; i < TO_CYCLES && !acked; i++) begin
      @(negedge clk);
      instr    = ins;
      imem_ack = (i == fdly);
      #1;
      checkOutput("fetch_state", 32'(state), 32'd1);
      checkOutput("fetch_imem_req", 32'(imem_req), 32'd1);
      checkOutput("fetch_ir_we", 32'(ir_we), 32'(i == fdly));
      acked = (i == fdly);
    end
    if (!acked) begin
      @(negedge clk); #1;
      checkOutput("fetch_to_state", 32'(state), 32'd6);
      checkOutput("fetch_to_flag", 32'(mem_timeout), 32'd1);
      checkOutput("fetch_to_req", 32'(imem_req), 32'd0);
      trapped = 1'b1;
      return;
    end
    @(posedge clk); #1; imem_ack = 1'b0;

    @(negedge clk); #1;
    checkOutput("dec_state", 32'(state), 32'd2);
    checkOutput("dec_strobes", 32'({imem_req, dmem_req, regwrite, pc_we, ir_we}), 32'd0);
    if (!e.legal) begin
      @(negedge clk); #1;
      checkOutput("ill_state", 32'(state), 32'd6);
      checkOutput("ill_flag", 32'(illegal), 32'd1);
      checkOutput("ill_imem_req", 32'(imem_req), 32'd0);
      trapped = 1'b1;
      return;
    end

    @(negedge clk);
    zero = z;
    #1;
    checkOutput("exec_state", 32'(state), 32'd3);
    checkOutput("exec_aluctl", 32'(aluctl), 32'(e.alu));
    checkOutput("exec_alusrc", 32'(alusrc), 32'(e.imm));
    checkOutput("exec_regwrite", 32'(regwrite), 32'd0);
    if (e.kind == K_BR) begin
      taken = e.brz ? z : !z;
      checkOutput("br_pc_we", 32'(pc_we), 32'd1);
      checkOutput("br_pc_src", 32'(pc_src), taken ? 32'd1 : 32'd0);
      return;
    end
    checkOutput("exec_pc_we", 32'(pc_we), 32'd0);

    if (e.kind == K_LW || e.kind == K_SW) begin
      acked = 1'b0;
      for (int j = 0; j < TO_CYCLES && !acked; j++) begin
        @(negedge clk);
        dmem_ack = (j == mdly);
        #1;
        checkOutput("mem_state", 32'(state), 32'd4);
        checkOutput("mem_dmem_req", 32'(dmem_req), 32'd1);
        checkOutput("mem_memwrite", 32'(memwrite), 32'(e.kind == K_SW));
        checkOutput("mem_pc_we", 32'(pc_we), 32'(e.kind == K_SW && j == mdly));
        checkOutput("mem_regwrite", 32'(regwrite), 32'd0);
        checkOutput("mem_aluctl", 32'(aluctl), 32'd2);
        checkOutput("mem_alusrc", 32'(alusrc), 32'd1);
        acked = (j == mdly);
      end
      if (!acked) begin
        @(negedge clk); #1;
        checkOutput("mem_to_state", 32'(state), 32'd6);
        checkOutput("mem_to_flag", 32'(mem_timeout), 32'd1);
        checkOutput("mem_to_req", 32'(dmem_req), 32'd0);
        trapped = 1'b1;
        return;
      end
      @(posedge clk); #1; dmem_ack = 1'b0;
      if (e.kind == K_SW) return;
    end

    @(negedge clk); #1;
    checkOutput("wb_state", 32'(state), 32'd5);
    checkOutput("wb_regwrite", 32'(regwrite), 32'd1);
    checkOutput("wb_pc_we", 32'(pc_we), 32'd1);
    checkOutput("wb_pc_src", 32'(pc_src),
                (e.kind == K_JAL) ? 32'd2 : (e.kind == K_JALR) ? 32'd3 : 32'd0);
    checkOutput("wb_mem2reg", 32'(mem2reg), 32'(e.kind == K_LW));
    checkOutput("wb_is_lui", 32'(is_lui), 32'(e.kind == K_LUI));
    checkOutput("wb_aluctl", 32'(aluctl), 32'(e.alu));
    checkOutput("wb_alusrc", 32'(alusrc), 32'(e.imm));
    checkOutput("wb_dmem_req", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    bit          tr;
    logic [31:0] ins;
    $display("[TB] starting multicycle_control_unit bench");
    doReset();

    applyStimulus(32'h002081B3, 1, 0, 1'b0, tr);
    applyStimulus(32'h0020A023, 0, 3, 1'b0, tr);
    applyStimulus(32'h00208063, 0, 0, 1'b1, tr);
    applyStimulus(32'h00208063, 2, 0, 1'b0, tr);
    applyStimulus(32'h0020C063, 0, 0, 1'b0, tr);
    if (tr) doReset();

    applyStimulus(32'h0000007F, 0, 0, 1'b0, tr);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_ack = i[0];
      dmem_ack = i[1];
      #1;
      checkOutput("trap_state", 32'(state), 32'd6);
      checkOutput("trap_illegal", 32'(illegal), 32'd1);
      checkOutput("trap_imem_req", 32'(imem_req), 32'd0);
      checkOutput("trap_ir_we", 32'(ir_we), 32'd0);
    end
    doReset();

    applyStimulus(32'h002081B3, TO_CYCLES, 0, 1'b0, tr);
    doReset();
    applyStimulus(32'h002081B3, TO_CYCLES - 1, 0, 1'b0, tr);
    applyStimulus(32'h0000A183, 0, TO_CYCLES - 1, 1'b0, tr);
    applyStimulus(32'h0000A183, 0, TO_CYCLES, 1'b0, tr);
    doReset();

    // Reset asserted while a load waits in MEM
    @(negedge clk);
    instr    = 32'h0000A183;
    imem_ack = 1'b1;
    @(posedge clk); #1; imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("mid_mem_state", 32'(state), 32'd4);
    checkOutput("mid_mem_req", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("async_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    checkOutput("release_fetch", 32'(state), 32'd1);

    for (int k = 0; k < 40; k++) begin
      ins = gen_instr();
      applyStimulus(ins, $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0) ? TO_CYCLES : $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), tr);
      if (tr) doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
